// File: rtl/nibble_tx_pkg.sv
// rtl/nibble_tx_pkg.sv - shared types and frame constants for the nibble serialiser
// Contents: state_t FSM encoding, frame bit counts, frame_cycles() length helper.
package nibble_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // One start bit, four data bits, one stop bit; parity adds one more.
  localparam int NIBBLE_BITS     = 4;
  localparam int FRAME_BITS_BASE = 2 + NIBBLE_BITS;

  // Clock cycles from acceptance to the return to IDLE.
  function automatic int frame_cycles(input int clks_per_bit, input int parity_en);
    return (FRAME_BITS_BASE + parity_en) * clks_per_bit;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit cycle counter producing an end-of-bit tick
// Ports: Clock, Reset_n (async, active-low), clear (hold counter at 0),
//        tick (high in the last cycle of each bit time).
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With CLKS_PER_BIT=1 the counter stays at 0 and ticks every cycle.
  assign tick = ~clear & (cnt == LAST);

endmodule

// File: rtl/nibble_tx.sv
// rtl/nibble_tx.sv - serialises a 4-bit nibble as start/data/parity/stop frame
// Ports: Clock, Reset_n (async, active-low), Data[3:0] + Valid (input nibble),
//        Ready (accepting, IDLE only), Sout (serial line, idle high),
//        Busy (frame in progress), Done (one-cycle pulse on frame completion).
module nibble_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] Data,
  input  logic       Valid,
  output logic       Ready,
  output logic       Sout,
  output logic       Busy,
  output logic       Done
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] shreg;
  logic [1:0] bit_idx;
  logic       done_q;
  logic       tick;
  logic       accept;

  assign accept = Valid & (state == IDLE);

  // The timer is held cleared in IDLE so every frame starts on a fresh bit time.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .clear  (state == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == STOP) & tick;
      if (accept) begin
        shreg <= Data;
      end
      // Two-bit index wraps 3 -> 0 on its own, ready for the next frame.
      if (state == DATA && tick) begin
        bit_idx <= bit_idx + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Valid) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bit_idx == 2'd3) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line level decoded from registered state only; Data/Valid never reach Sout.
  always_comb begin
    Sout = 1'b1;
    case (state)
      START:   Sout = 1'b0;
      DATA:    Sout = shreg[bit_idx];
      PARITY:  Sout = ^shreg;
      default: Sout = 1'b1;
    endcase
  end

  assign Ready = (state == IDLE);
  assign Busy  = ~Ready;
  assign Done  = done_q;

endmodule

// File: tb/tb_nibble_tx.sv
// tb/tb_nibble_tx.sv - directed self-checking bench for nibble_tx
module tb_nibble_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data;
  logic       valid;
  int         sel;
  logic [2:0] sout_v, ready_v, busy_v, done_v;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  nibble_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .Clock(clk), .Reset_n(rst_n), .Data(data), .Valid(valid && sel == 0),
    .Ready(ready_v[0]), .Sout(sout_v[0]), .Busy(busy_v[0]), .Done(done_v[0])
  );

  nibble_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
    .Clock(clk), .Reset_n(rst_n), .Data(data), .Valid(valid && sel == 1),
    .Ready(ready_v[1]), .Sout(sout_v[1]), .Busy(busy_v[1]), .Done(done_v[1])
  );

  nibble_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1)) dut_c (
    .Clock(clk), .Reset_n(rst_n), .Data(data), .Valid(valid && sel == 2),
    .Ready(ready_v[2]), .Sout(sout_v[2]), .Busy(busy_v[2]), .Done(done_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags();
    return {ready_v[sel], busy_v[sel], done_v[sel]};
  endfunction

  // Expected line level for frame bit number bitn.
  function automatic logic exp_sout(input logic [3:0] d, input int p, input int bitn);
    if (bitn == 0) return 1'b0;
    if (bitn <= 4) return d[bitn-1];
    if (bitn == 5 && p != 0) return d[0] ^ d[1] ^ d[2] ^ d[3];
    return 1'b1;
  endfunction

  // Present a nibble for one edge; returns at the first sample after acceptance.
  task automatic kick(input logic [3:0] d, input bit hold);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = hold;
  endtask

  task automatic body(input string tag, input logic [3:0] d, input int p, input int c,
                      input bit hold, input bit chain, input logic [3:0] nd);
    int n;
    n = (6 + p) * c;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s sout k=%0d", tag, k), 32'(sout_v[sel]), 32'(exp_sout(d, p, k / c)));
      check($sformatf("%s flags k=%0d", tag, k), 32'(flags()), 32'(3'b010));
      if (hold) begin
        valid = (k < n - 1);
        data  = 4'($urandom);
      end
      @(negedge clk);
    end
    check($sformatf("%s done cycle flags", tag), 32'(flags()), 32'(3'b101));
    check($sformatf("%s done cycle sout", tag), 32'(sout_v[sel]), 32'(1'b1));
    if (chain) begin
      data  = nd;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
    end else begin
      @(negedge clk);
      check($sformatf("%s after done flags", tag), 32'(flags()), 32'(3'b100));
    end
  endtask

  initial begin
    valid = 1'b0;
    data  = 4'h0;
    sel   = 0;
    rst_n = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check($sformatf("reset flags dut%0d", s), 32'(flags()), 32'(3'b100));
      check($sformatf("reset sout dut%0d", s), 32'(sout_v[s]), 32'(1'b1));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    kick(4'b1011, 1'b0);
    body("a1011", 4'b1011, 1, 4, 1'b0, 1'b0, 4'h0);

    sel = 1;
    kick(4'b0110, 1'b0);
    body("b0110", 4'b0110, 0, 4, 1'b0, 1'b0, 4'h0);

    sel = 0;
    kick(4'h9, 1'b1);
    body("hold9", 4'h9, 1, 4, 1'b1, 1'b0, 4'h0);

    sel = 0;
    kick(4'h3, 1'b0);
    body("b2b3", 4'h3, 1, 4, 1'b0, 1'b1, 4'hF);
    body("b2bF", 4'hF, 1, 4, 1'b0, 1'b0, 4'h0);

    sel = 0;
    kick(4'hA, 1'b0);
    repeat (10) @(negedge clk);
    check("mid data flags", 32'(flags()), 32'(3'b010));
    #2 rst_n = 1'b0;
    #1;
    check("async reset sout", 32'(sout_v[0]), 32'(1'b1));
    check("async reset flags", 32'(flags()), 32'(3'b100));
    @(negedge clk);
    check("held reset flags", 32'(flags()), 32'(3'b100));
    rst_n = 1'b1;
    data  = 4'h5;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    body("rst5", 4'h5, 1, 4, 1'b0, 1'b0, 4'h0);

    sel = 2;
    kick(4'h0, 1'b0);
    body("c0", 4'h0, 1, 1, 1'b0, 1'b0, 4'h0);
    kick(4'hD, 1'b0);
    body("cD", 4'hD, 1, 1, 1'b0, 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
